// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, rx FSM states, vote helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-clk pulse every CLK_DIV clocks.
module uart_tick_gen #(
  parameter int CLK_DIV = 325
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = $clog2(CLK_DIV);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority vote and valid/ready output.
// Define UART_RX_BREAK_DET_EN to add the break_det output.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 325,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 break_det,
`endif
  output logic                 busy
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  logic tick;
  logic rx_m, rx_s;

  rx_state_t state_q, state_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic stop2_q, stop2_d;
  logic armed_q, armed_d;
  logic ppar_q, ppar_d;
  logic pfrm_q, pfrm_d;
  logic sa_q, sa_d;
  logic sb_q, sb_d;

  logic at_a, at_b, at_c, at_last;
  logic maj, par_exp, frm_now;
  logic deliver;
  logic load, drop, take;

`ifdef UART_RX_BREAK_DET_EN
  logic pbit_q, pbit_d;
  logic brk;
  assign brk = (shreg_q == '0) && frm_now &&
               (PARITY == PAR_NONE || !pbit_q);
`endif

  uart_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign at_a    = (samp_q == SW'(M - 1));
  assign at_b    = (samp_q == SW'(M));
  assign at_c    = (samp_q == SW'(M + 1));
  assign at_last = (samp_q == SW'(OVERSAMPLE - 1));

  assign maj     = maj3(sa_q, sb_q, rx_s);
  assign frm_now = pfrm_q | ~maj;
  assign par_exp = (PARITY == PAR_ODD) ? ~^shreg_q : ^shreg_q;
  assign busy    = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    stop2_d = stop2_q;
    armed_d = armed_q;
    ppar_d  = ppar_q;
    pfrm_d  = pfrm_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    deliver = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    pbit_d  = pbit_q;
`endif
    if (tick) begin
      samp_d = at_last ? '0 : samp_q + 1'b1;
      if (at_a) sa_d = rx_s;
      if (at_b) sb_d = rx_s;
      unique case (state_q)
        S_IDLE: begin
          samp_d = '0;
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = S_START;
            stop2_d = 1'b0;
            ppar_d  = 1'b0;
            pfrm_d  = 1'b0;
          end
        end
        S_START: begin
          if (at_c && maj) begin
            state_d = S_IDLE;
          end else if (at_last) begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
        S_DATA: begin
          if (at_c) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
          if (at_last) begin
            bit_d = bit_q + 1'b1;
            if (bit_q == BW'(DATA_BITS - 1))
              state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (at_c) begin
            if (maj != par_exp) ppar_d = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
            pbit_d = maj;
`endif
          end
          if (at_last) state_d = S_STOP;
        end
        S_STOP: begin
          if (at_c) begin
            pfrm_d = frm_now;
            if (STOP_BITS == 1 || stop2_q) begin
              // early return to IDLE lets back-to-back frames start
              deliver = 1'b1;
              state_d = S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
              armed_d = maj;
`else
              armed_d = 1'b1;
`endif
            end
          end else if (at_last) begin
            stop2_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= S_IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      stop2_q <= 1'b0;
      armed_q <= 1'b0;
      ppar_q  <= 1'b0;
      pfrm_q  <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      pbit_q  <= 1'b0;
`endif
    end else begin
      rx_m    <= rx_in;
      rx_s    <= rx_m;
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      stop2_q <= stop2_d;
      armed_q <= armed_d;
      ppar_q  <= ppar_d;
      pfrm_q  <= pfrm_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
`ifdef UART_RX_BREAK_DET_EN
      pbit_q  <= pbit_d;
`endif
    end
  end

  assign load = deliver && (!valid || ready);
  assign drop = deliver && valid && !ready;
  assign take = !deliver && valid && ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det  <= 1'b0;
`endif
    end else begin
      unique case (1'b1)
        load: begin
          data_out   <= shreg_q;
          valid      <= 1'b1;
          parity_err <= ppar_q;
          frame_err  <= frm_now;
          overrun    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          break_det  <= brk;
`endif
        end
        drop: overrun <= 1'b1;
        take: begin
          valid      <= 1'b0;
          parity_err <= 1'b0;
          frame_err  <= 1'b0;
          overrun    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          break_det  <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8N1 and 8E1 instances, CLK_DIV=4, OVERSAMPLE=16.
module tb_uart_rx_param;

  localparam int BT = 4 * 16;

  typedef struct packed {
    logic [7:0] d;
    logic pe;
    logic fe;
    logic ov;
    logic bk;
  } word_t;

  typedef struct {
    bit e;
    logic [7:0] d;
    bit pb;
    bit sb;
    bit xpe;
    bit xfe;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_n = 1'b1, rx_e = 1'b1;
  logic rdy_n = 1'b1, rdy_e = 1'b1;
  logic [7:0] dn, de;
  logic vn, ve, pen, pee, fen, fee, ovn, ove, bn, be;
  logic brk_n, brk_e;

  int total = 0;
  int bad = 0;
  int bcnt_n = 0;
  word_t got_n[$];
  word_t got_e[$];

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1)
  ) dut_n (
    .clk(clk), .rst(rst), .rx_in(rx_n), .ready(rdy_n),
    .data_out(dn), .valid(vn), .parity_err(pen),
    .frame_err(fen), .overrun(ovn),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk_n),
`endif
    .busy(bn)
  );

  uart_rx_param #(
    .CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1)
  ) dut_e (
    .clk(clk), .rst(rst), .rx_in(rx_e), .ready(rdy_e),
    .data_out(de), .valid(ve), .parity_err(pee),
    .frame_err(fee), .overrun(ove),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk_e),
`endif
    .busy(be)
  );

`ifndef UART_RX_BREAK_DET_EN
  assign brk_n = 1'b0;
  assign brk_e = 1'b0;
`endif

  always @(negedge clk) begin
    if (vn && rdy_n) got_n.push_back({dn, pen, fen, ovn, brk_n});
    if (ve && rdy_e) got_e.push_back({de, pee, fee, ove, brk_e});
    if (bn) bcnt_n++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int qsize(input bit e);
    return e ? got_e.size() : got_n.size();
  endfunction

  task automatic chk_word(input string nm, input bit e, input int idx,
                          input word_t x);
    word_t w;
    if (qsize(e) > idx) begin
      w = e ? got_e[idx] : got_n[idx];
      chk({nm, "_data"}, w.d, x.d);
      chk({nm, "_perr"}, w.pe, x.pe);
      chk({nm, "_ferr"}, w.fe, x.fe);
      chk({nm, "_ovr"}, w.ov, x.ov);
`ifdef UART_RX_BREAK_DET_EN
      chk({nm, "_brk"}, w.bk, x.bk);
`endif
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input bit e, input logic v);
    if (e) rx_e = v;
    else rx_n = v;
  endtask

  task automatic send(input bit e, input logic [7:0] d,
                      input bit pb, input bit sb);
    put(e, 1'b0);
    cyc(BT);
    for (int i = 0; i < 8; i++) begin
      put(e, d[i]);
      cyc(BT);
    end
    if (e) begin
      put(e, pb);
      cyc(BT);
    end
    put(e, sb);
    cyc(BT);
    put(e, 1'b1);
  endtask

  vec_t tv[8];
  word_t exq[$];

  initial begin
    int n0, b0, dl, nr;
    logic [7:0] d;
    bit flip, sb, pb, pe_x, bk_x;

    tv[0] = '{0, 8'hAB, 0, 1, 0, 0};
    tv[1] = '{1, 8'h46, 1, 1, 0, 0};
    tv[2] = '{1, 8'h46, 0, 1, 1, 0};
    tv[3] = '{0, 8'h3C, 0, 0, 0, 1};
    tv[4] = '{0, 8'h55, 0, 1, 0, 0};
    tv[5] = '{1, 8'h00, 0, 1, 0, 0};
    tv[6] = '{1, 8'hFF, 0, 1, 0, 0};
    tv[7] = '{1, 8'h01, 0, 0, 1, 1};

    cyc(5);
    @(negedge clk);
    chk("rst_valid_n", vn, 0);
    chk("rst_valid_e", ve, 0);
    chk("rst_busy_n", bn, 0);
    chk("rst_busy_e", be, 0);
    chk("rst_data_n", dn, 0);
    chk("rst_flags_n", {pen, fen, ovn}, 0);
`ifdef UART_RX_BREAK_DET_EN
    chk("rst_brk_n", brk_n, 0);
`endif
    rst = 1'b1;
    cyc(2 * BT);

    for (int i = 0; i < 8; i++) begin
      n0 = qsize(tv[i].e);
      b0 = bcnt_n;
      send(tv[i].e, tv[i].d, tv[i].pb, tv[i].sb);
      cyc(2 * BT);
      chk($sformatf("vec%0d_count", i), qsize(tv[i].e), n0 + 1);
      chk_word($sformatf("vec%0d", i), tv[i].e, n0,
               {tv[i].d, tv[i].xpe, tv[i].xfe, 1'b0, 1'b0});
      if (i == 0) begin
        dl = bcnt_n - b0;
        chk("busy_len_8n1", (dl >= 9 * BT && dl <= 10 * BT), 1);
        chk("busy_low_after", bn, 0);
      end
    end

    n0 = qsize(0);
    b0 = bcnt_n;
    put(0, 1'b0);
    cyc(12);
    put(0, 1'b1);
    cyc(48);
    @(negedge clk);
    chk("glitch_busy_seen", bcnt_n != b0, 1);
    chk("glitch_busy_end", bn, 0);
    cyc(2 * BT);
    chk("glitch_no_word", qsize(0), n0);
    chk("glitch_flags", {vn, pen, fen, ovn}, 0);

    rdy_n = 1'b0;
    n0 = qsize(0);
    send(0, 8'h11, 0, 1);
    cyc(BT);
    @(negedge clk);
    chk("ovr_first_valid", vn, 1);
    chk("ovr_first_ovr", ovn, 0);
    send(0, 8'h22, 0, 1);
    cyc(BT);
    @(negedge clk);
    chk("ovr_held_valid", vn, 1);
    chk("ovr_held_data", dn, 8'h11);
    chk("ovr_flag", ovn, 1);
    chk("ovr_ferr", fen, 0);
    @(posedge clk);
    #1;
    rdy_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ovr_valid_clr", vn, 0);
    chk("ovr_flag_clr", ovn, 0);
    cyc(2 * BT);
    chk("ovr_count", qsize(0), n0 + 1);
    chk_word("ovr_word", 0, n0, {8'h11, 1'b0, 1'b0, 1'b1, 1'b0});

    n0 = qsize(0);
    put(0, 1'b0);
    cyc(3 * BT);
    rst = 1'b0;
    cyc(4);
    @(negedge clk);
    chk("mid_rst_busy", bn, 0);
    chk("mid_rst_data", dn, 0);
    chk("mid_rst_valid", vn, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(2 * BT);
    @(negedge clk);
    chk("low_unarmed_busy", bn, 0);
    put(0, 1'b1);
    cyc(2 * BT);
    send(0, 8'h5A, 0, 1);
    cyc(2 * BT);
    chk("mid_rst_count", qsize(0), n0 + 1);
    chk_word("mid_rst_word", 0, n0, {8'h5A, 1'b0, 1'b0, 1'b0, 1'b0});

    n0 = qsize(0);
    put(0, 1'b0);
`ifdef UART_RX_BREAK_DET_EN
    cyc(20 * BT);
    put(0, 1'b1);
    cyc(8 * BT);
    chk("break_count", qsize(0), n0 + 1);
    chk_word("break_word", 0, n0, {8'h00, 1'b0, 1'b1, 1'b0, 1'b1});
`else
    cyc(15 * BT);
    put(0, 1'b1);
    cyc(8 * BT);
    chk("lowline_count", qsize(0), n0 + 2);
    chk_word("lowline_w0", 0, n0, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    chk_word("lowline_w1", 0, n0 + 1, {8'hF0, 1'b0, 1'b0, 1'b0, 1'b0});
`endif

    n0 = qsize(1);
    nr = 14;
    for (int k = 0; k < nr; k++) begin
      d = 8'($urandom);
      flip = ($urandom_range(3) == 0);
      sb = ($urandom_range(5) != 0);
      pb = 1'(($countones(d) + (flip ? 1 : 0)) % 2);
      pe_x = (($countones(d) + pb) % 2) != 0;
`ifdef UART_RX_BREAK_DET_EN
      bk_x = (d == 8'h00) && !sb && !pb;
`else
      bk_x = 1'b0;
`endif
      exq.push_back({d, pe_x, !sb, 1'b0, bk_x});
      send(1, d, pb, sb);
      cyc(sb ? $urandom_range(0, 40) : BT + $urandom_range(0, 40));
    end
    cyc(2 * BT);
    chk("rand_count", qsize(1), n0 + nr);
    for (int k = 0; k < nr; k++)
      chk_word($sformatf("rand%0d", k), 1, n0 + k, exq[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
